// File: rtl/rvc_expander.sv
// RV64C decompressor: expands 16-bit compressed instructions to 32-bit RV64I form,
// flags illegal encodings and records the PC of the first illegal encoding seen.
module rvc_expander (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] inst_o,
  output logic        is_compressed_o,
  output logic        illegal_o,
  output logic        illegal_seen_o,
  output logic [63:0] illegal_pc_o
);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [31:0] EBREAK      = 32'h00100073;
  localparam logic [6:0] F7_ZERO      = 7'b0000000;
  localparam logic [6:0] F7_ALT       = 7'b0100000;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  // Branch offset passed as imm[12:1]; bit 0 is always zero.
  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd0, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  // Jump offset passed as imm[20:1].
  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [11:0] imm6;
  logic [5:0]  shamt;
  logic [9:0]  addi4spn_imm;
  logic [6:0]  lw_off;
  logic [7:0]  ld_off;
  logic [9:0]  a16_imm;
  logic [11:0] j_imm;
  logic [8:0]  b_imm;
  logic [7:0]  lwsp_off;
  logic [8:0]  ldsp_off;
  logic [7:0]  swsp_off;
  logic [8:0]  sdsp_off;
  logic [31:0] expanded;
  logic        ill;

  assign c            = inst_i[15:0];
  assign rd           = c[11:7];
  assign rs2          = c[6:2];
  assign rdp          = {2'b01, c[4:2]};
  assign rs1p         = {2'b01, c[9:7]};
  assign imm6         = {{6{c[12]}}, c[12], c[6:2]};
  assign shamt        = {c[12], c[6:2]};
  assign addi4spn_imm = {c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign lw_off       = {c[5], c[12:10], c[6], 2'b00};
  assign ld_off       = {c[6:5], c[12:10], 3'b000};
  assign a16_imm      = {c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
  assign j_imm        = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
  assign b_imm        = {c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
  assign lwsp_off     = {c[3:2], c[12], c[6:4], 2'b00};
  assign ldsp_off     = {c[4:2], c[12], c[6:5], 3'b000};
  assign swsp_off     = {c[8:7], c[12:9], 2'b00};
  assign sdsp_off     = {c[9:7], c[12:10], 3'b000};

  always_comb begin
    expanded = '0;
    ill      = 1'b0;
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: begin
            if (addi4spn_imm == 10'd0) ill = 1'b1;
            else expanded = enc_i({2'b00, addi4spn_imm}, 5'd2, 3'b000, rdp, OPC_OP_IMM);
          end
          3'b010:  expanded = enc_i({5'd0, lw_off}, rs1p, 3'b010, rdp, OPC_LOAD);
          3'b011:  expanded = enc_i({4'd0, ld_off}, rs1p, 3'b011, rdp, OPC_LOAD);
          3'b110:  expanded = enc_s({5'd0, lw_off}, rdp, rs1p, 3'b010);
          3'b111:  expanded = enc_s({4'd0, ld_off}, rdp, rs1p, 3'b011);
          default: ill = 1'b1;
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000: expanded = enc_i(imm6, rd, 3'b000, rd, OPC_OP_IMM);
          3'b001: begin
            if (rd == 5'd0) ill = 1'b1;
            else expanded = enc_i(imm6, rd, 3'b000, rd, OPC_OP_IMM32);
          end
          3'b010: expanded = enc_i(imm6, 5'd0, 3'b000, rd, OPC_OP_IMM);
          3'b011: begin
            if (rd == 5'd2) begin
              if (a16_imm == 10'd0) ill = 1'b1;
              else expanded = enc_i({{2{a16_imm[9]}}, a16_imm}, 5'd2, 3'b000, 5'd2, OPC_OP_IMM);
            end else begin
              if (shamt == 6'd0) ill = 1'b1;
              else expanded = {{14{c[12]}}, shamt, rd, OPC_LUI};
            end
          end
          3'b100: begin
            case (c[11:10])
              2'b00: expanded = enc_i({6'b000000, shamt}, rs1p, 3'b101, rs1p, OPC_OP_IMM);
              2'b01: expanded = enc_i({6'b010000, shamt}, rs1p, 3'b101, rs1p, OPC_OP_IMM);
              2'b10: expanded = enc_i(imm6, rs1p, 3'b111, rs1p, OPC_OP_IMM);
              default: begin
                if (!c[12]) begin
                  case (c[6:5])
                    2'b00:   expanded = enc_r(F7_ALT, rdp, rs1p, 3'b000, rs1p, OPC_OP);
                    2'b01:   expanded = enc_r(F7_ZERO, rdp, rs1p, 3'b100, rs1p, OPC_OP);
                    2'b10:   expanded = enc_r(F7_ZERO, rdp, rs1p, 3'b110, rs1p, OPC_OP);
                    default: expanded = enc_r(F7_ZERO, rdp, rs1p, 3'b111, rs1p, OPC_OP);
                  endcase
                end else begin
                  case (c[6:5])
                    2'b00:   expanded = enc_r(F7_ALT, rdp, rs1p, 3'b000, rs1p, OPC_OP32);
                    2'b01:   expanded = enc_r(F7_ZERO, rdp, rs1p, 3'b000, rs1p, OPC_OP32);
                    default: ill = 1'b1;
                  endcase
                end
              end
            endcase
          end
          3'b101:  expanded = enc_j({{9{c[12]}}, j_imm[11:1]}, 5'd0);
          3'b110:  expanded = enc_b({{4{c[12]}}, b_imm[8:1]}, rs1p, 3'b000);
          default: expanded = enc_b({{4{c[12]}}, b_imm[8:1]}, rs1p, 3'b001);
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b000: expanded = enc_i({6'b000000, shamt}, rd, 3'b001, rd, OPC_OP_IMM);
          3'b010: begin
            if (rd == 5'd0) ill = 1'b1;
            else expanded = enc_i({4'd0, lwsp_off}, 5'd2, 3'b010, rd, OPC_LOAD);
          end
          3'b011: begin
            if (rd == 5'd0) ill = 1'b1;
            else expanded = enc_i({3'd0, ldsp_off}, 5'd2, 3'b011, rd, OPC_LOAD);
          end
          3'b100: begin
            if (!c[12]) begin
              if (rs2 != 5'd0) expanded = enc_r(F7_ZERO, rs2, 5'd0, 3'b000, rd, OPC_OP);
              else if (rd == 5'd0) ill = 1'b1;
              else expanded = enc_i(12'd0, rd, 3'b000, 5'd0, OPC_JALR);
            end else begin
              if (rs2 != 5'd0) expanded = enc_r(F7_ZERO, rs2, rd, 3'b000, rd, OPC_OP);
              else if (rd == 5'd0) expanded = EBREAK;
              else expanded = enc_i(12'd0, rd, 3'b000, 5'd1, OPC_JALR);
            end
          end
          3'b110:  expanded = enc_s({4'd0, swsp_off}, rs2, 5'd2, 3'b010);
          3'b111:  expanded = enc_s({3'd0, sdsp_off}, rs2, 5'd2, 3'b011);
          default: ill = 1'b1;
        endcase
      end
      default: expanded = inst_i;
    endcase
    // Illegal encodings become an all-zero word the main decoder rejects.
    if (ill) expanded = '0;
  end

  assign inst_o          = expanded;
  assign illegal_o       = ill;
  assign is_compressed_o = (inst_i[1:0] != 2'b11);

  // First-illegal diagnostic capture; holds until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal_seen_o <= 1'b0;
      illegal_pc_o   <= '0;
    end else if (illegal_o && !illegal_seen_o) begin
      illegal_seen_o <= 1'b1;
      illegal_pc_o   <= pc_i;
    end
  end

endmodule

// File: tb/tb_rvc_expander.sv
// Directed bench for rvc_expander: expansion vectors, pass-through, illegal capture
// and asynchronous reset of the diagnostic registers.
module tb_rvc_expander;

  logic        clock;
  logic        reset;
  logic [63:0] pc_i;
  logic [31:0] inst_i;
  logic [31:0] inst_o;
  logic        is_compressed_o;
  logic        illegal_o;
  logic        illegal_seen_o;
  logic [63:0] illegal_pc_o;

  int checks = 0;
  int errors = 0;

  rvc_expander dut (
    .clock           (clock),
    .reset           (reset),
    .pc_i            (pc_i),
    .inst_i          (inst_i),
    .inst_o          (inst_o),
    .is_compressed_o (is_compressed_o),
    .illegal_o       (illegal_o),
    .illegal_seen_o  (illegal_seen_o),
    .illegal_pc_o    (illegal_pc_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    reset  = 1'b1;
    pc_i   = 64'h0;
    inst_i = 32'h00000013;
    #3;
    checks++;
    if (illegal_seen_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_seen: got %b expected 0", illegal_seen_o);
    end
    checks++;
    if (illegal_pc_o !== 64'h0) begin
      errors++;
      $display("FAIL reset_pc: got %h expected 0", illegal_pc_o);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_expand();
    logic [31:0] vin  [12];
    logic [31:0] vexp [12];
    logic        vcmp [12];
    vin[0]  = 32'h00004501; vexp[0]  = 32'h00000513; vcmp[0]  = 1'b1; // c.li a0,0
    vin[1]  = 32'h00001141; vexp[1]  = 32'hFF010113; vcmp[1]  = 1'b1; // c.addi sp,-16
    vin[2]  = 32'h0000E406; vexp[2]  = 32'h00113423; vcmp[2]  = 1'b1; // c.sdsp ra,8(sp)
    vin[3]  = 32'h00008082; vexp[3]  = 32'h00008067; vcmp[3]  = 1'b1; // c.jr ra
    vin[4]  = 32'h00009002; vexp[4]  = 32'h00100073; vcmp[4]  = 1'b1; // c.ebreak
    vin[5]  = 32'h000041C8; vexp[5]  = 32'h0045A503; vcmp[5]  = 1'b1; // c.lw a0,4(a1)
    vin[6]  = 32'h0000BFFD; vexp[6]  = 32'hFFFFF06F; vcmp[6]  = 1'b1; // c.j -2
    vin[7]  = 32'h0000C101; vexp[7]  = 32'h00050063; vcmp[7]  = 1'b1; // c.beqz a0,0
    vin[8]  = 32'h00008C05; vexp[8]  = 32'h40940433; vcmp[8]  = 1'b1; // c.sub s0,s1
    vin[9]  = 32'h00000013; vexp[9]  = 32'h00000013; vcmp[9]  = 1'b0; // 32-bit addi
    vin[10] = 32'hABCD4501; vexp[10] = 32'h00000513; vcmp[10] = 1'b1; // upper half ignored
    vin[11] = 32'h12345677; vexp[11] = 32'h12345677; vcmp[11] = 1'b0; // 32-bit pass-through
    for (int i = 0; i < 12; i++) begin
      inst_i = vin[i];
      pc_i   = 64'h1000 + 64'(i * 2);
      #1;
      checks++;
      if (inst_o !== vexp[i]) begin
        errors++;
        $display("FAIL expand_inst[%0d] in=%h: got %h expected %h", i, vin[i], inst_o, vexp[i]);
      end
      checks++;
      if (is_compressed_o !== vcmp[i]) begin
        errors++;
        $display("FAIL expand_cmp[%0d]: got %b expected %b", i, is_compressed_o, vcmp[i]);
      end
      checks++;
      if (illegal_o !== 1'b0) begin
        errors++;
        $display("FAIL expand_ill[%0d]: got %b expected 0", i, illegal_o);
      end
      @(negedge clock);
    end
    checks++;
    if (illegal_seen_o !== 1'b0) begin
      errors++;
      $display("FAIL legal_no_capture: got %b expected 0", illegal_seen_o);
    end
  endtask

  task automatic test_illegal_capture();
    inst_i = 32'h00000000;
    pc_i   = 64'h80000010;
    #1;
    checks++;
    if (inst_o !== 32'h0 || illegal_o !== 1'b1) begin
      errors++;
      $display("FAIL ill_zero: got inst %h ill %b expected 00000000 1", inst_o, illegal_o);
    end
    checks++;
    if (illegal_seen_o !== 1'b0) begin
      errors++;
      $display("FAIL ill_before_edge: got %b expected 0", illegal_seen_o);
    end
    @(posedge clock);
    #1;
    checks++;
    if (illegal_seen_o !== 1'b1) begin
      errors++;
      $display("FAIL ill_seen: got %b expected 1", illegal_seen_o);
    end
    checks++;
    if (illegal_pc_o !== 64'h80000010) begin
      errors++;
      $display("FAIL ill_pc: got %h expected 80000010", illegal_pc_o);
    end
    inst_i = 32'h00002001; // c.addiw with rd=0
    pc_i   = 64'h80000020;
    #1;
    checks++;
    if (inst_o !== 32'h0 || illegal_o !== 1'b1) begin
      errors++;
      $display("FAIL ill_addiw: got inst %h ill %b expected 00000000 1", inst_o, illegal_o);
    end
    @(posedge clock);
    @(posedge clock);
    #1;
    checks++;
    if (illegal_pc_o !== 64'h80000010 || illegal_seen_o !== 1'b1) begin
      errors++;
      $display("FAIL ill_hold: got pc %h seen %b expected 80000010 1", illegal_pc_o, illegal_seen_o);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    #2;
    reset  = 1'b1;
    inst_i = 32'h00004501;
    #1;
    checks++;
    if (illegal_seen_o !== 1'b0 || illegal_pc_o !== 64'h0) begin
      errors++;
      $display("FAIL async_reset: got seen %b pc %h expected 0 0", illegal_seen_o, illegal_pc_o);
    end
    checks++;
    if (inst_o !== 32'h00000513 || illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb: got %h ill %b expected 00000513 0", inst_o, illegal_o);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (illegal_seen_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_seen: got %b expected 0", illegal_seen_o);
    end
  endtask

  initial begin
    test_reset();
    test_expand();
    test_illegal_capture();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
